vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator and pixel output stage; next generation of the 640x480 driver.

---
 rtl/vga_pkg.sv | 47 ++++
 rtl/vga_delay_line.sv | 31 +++
 rtl/vga_timing_gen.sv | 161 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA types: timing constant sets, the per-pixel timing tuple and
// the packed-colour to 8-bit DAC expansion.
package vga_pkg;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic sol;
    logic sof;
  } tuple_t;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 800x600 @ 60 Hz, 40 MHz pixel clock
  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FP     = 40;
  localparam int VGA800_H_SYNC   = 128;
  localparam int VGA800_H_BP     = 88;
  localparam int VGA800_V_ACTIVE = 600;
  localparam int VGA800_V_FP     = 1;
  localparam int VGA800_V_SYNC   = 4;
  localparam int VGA800_V_BP     = 23;

  // Replicate the low n bits of f MSB-first across 8 bits.
  function automatic logic [7:0] expand8(input logic [7:0] f, input int unsigned n);
    logic [7:0]  r;
    int unsigned idx;
    int unsigned pos;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = n - 1 - (i % n);
      pos = 7 - i;
      r[pos[2:0]] = f[idx[2:0]];
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH clock-enabled shift register with synchronous clear.
// DEPTH=0 collapses to a plain wire.
module vga_delay_line #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = clock ^ clear ^ ce;
    assign dout = din;
  end else begin : g_sr
    logic [DEPTH-1:0][WIDTH-1:0] sr_q;
    always_ff @(posedge clock) begin
      if (clear) begin
        sr_q <= '0;
      end else if (ce) begin
        sr_q[0] <= din;
        for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
    end
    assign dout = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: issues pixel requests PIPE_DELAY ce-cycles ahead of
// the beam and registers sync/blank/colour aligned with the returned data.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE   = VGA640_H_ACTIVE,
  parameter int   H_FP       = VGA640_H_FP,
  parameter int   H_SYNC     = VGA640_H_SYNC,
  parameter int   H_BP       = VGA640_H_BP,
  parameter int   V_ACTIVE   = VGA640_V_ACTIVE,
  parameter int   V_FP       = VGA640_V_FP,
  parameter int   V_SYNC     = VGA640_V_SYNC,
  parameter int   V_BP       = VGA640_V_BP,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0,
  parameter int   R_BITS     = 3,
  parameter int   G_BITS     = 3,
  parameter int   B_BITS     = 2,
  parameter int   PIPE_DELAY = 2,
  parameter int   CNT_W      = 11,
  parameter int   FRAME_W    = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             ce,
  input  logic [R_BITS+G_BITS+B_BITS-1:0]  color_in,
  output logic [CNT_W-1:0]                 req_x,
  output logic [CNT_W-1:0]                 req_y,
  output logic                             req_valid,
  output logic                             hsync,
  output logic                             vsync,
  output logic [7:0]                       red,
  output logic [7:0]                       green,
  output logic [7:0]                       blue,
  output logic                             blank_n,
  output logic                             frame_start,
  output logic                             line_start,
  output logic [FRAME_W-1:0]               frame_count
);

  localparam int C_W     = R_BITS + G_BITS + B_BITS;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_B   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_E   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_B   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_E   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_bad_cnt
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 15 || R_BITS < 1 || R_BITS > 8 ||
      G_BITS < 1 || G_BITS > 8 || B_BITS < 1 || B_BITS > 8) begin : g_bad_par
    $error("vga_timing_gen: PIPE_DELAY or colour field width out of range");
  end

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (ce) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign req_x     = h_q;
  assign req_y     = v_q;
  assign req_valid = (h_q < H_ACT) && (v_q < V_ACT);

  tuple_t cur, tail;

  always_comb begin
    cur.active = req_valid;
    cur.hs     = (h_q >= HS_B) && (h_q < HS_E);
    cur.vs     = (v_q >= VS_B) && (v_q < VS_E);
    cur.sol    = (h_q == '0) && (v_q < V_ACT);
    cur.sof    = (h_q == '0) && (v_q == '0);
  end

  // Reset clears the line to the inactive tuple, so no stale sync leaks out.
  vga_delay_line #(
    .WIDTH($bits(tuple_t)),
    .DEPTH(PIPE_DELAY)
  ) u_dly (
    .clock(clock),
    .clear(reset),
    .ce   (ce),
    .din  (cur),
    .dout (tail)
  );

  logic [R_BITS-1:0] r_f;
  logic [G_BITS-1:0] g_f;
  logic [B_BITS-1:0] b_f;
  assign r_f = color_in[C_W-1 -: R_BITS];
  assign g_f = color_in[G_BITS+B_BITS-1 -: G_BITS];
  assign b_f = color_in[B_BITS-1:0];

  logic               hsync_q, vsync_q, blank_q, fs_q, ls_q;
  logic [7:0]         red_q, green_q, blue_q;
  logic [FRAME_W-1:0] fc_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hsync_q <= ~H_SYNC_POL;
      vsync_q <= ~V_SYNC_POL;
      blank_q <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      fc_q    <= '0;
    end else begin
      // Pulses last one clock even when ce stretches the pixel period.
      fs_q <= ce & tail.sof;
      ls_q <= ce & tail.sol;
      if (ce) begin
        hsync_q <= tail.hs ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_q <= tail.vs ? V_SYNC_POL : ~V_SYNC_POL;
        blank_q <= tail.active;
        red_q   <= tail.active ? expand8(8'(r_f), R_BITS) : '0;
        green_q <= tail.active ? expand8(8'(g_f), G_BITS) : '0;
        blue_q  <= tail.active ? expand8(8'(b_f), B_BITS) : '0;
        if (tail.sof) fc_q <= fc_q + 1'b1;
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Four differently parameterised generators on shared clock/ce/reset, checked
// every clock against a raster model derived from the ce-cycle count.
module tb_vga_timing_gen;

  localparam int NC = 4;
  localparam int PD [NC]  = '{2, 0, 5, 3};
  localparam int RB [NC]  = '{3, 3, 4, 5};
  localparam int GB [NC]  = '{3, 3, 4, 6};
  localparam int BB [NC]  = '{2, 2, 4, 5};
  localparam int HA [NC]  = '{20, 20, 20, 24};
  localparam int HF [NC]  = '{3, 3, 3, 4};
  localparam int HSW[NC]  = '{5, 5, 5, 8};
  localparam int HB [NC]  = '{4, 4, 4, 4};
  localparam int VA [NC]  = '{6, 6, 6, 5};
  localparam int VF [NC]  = '{2, 2, 2, 1};
  localparam int VSW[NC]  = '{2, 2, 2, 3};
  localparam int VB [NC]  = '{3, 3, 3, 2};
  localparam bit HP [NC]  = '{1'b0, 1'b0, 1'b1, 1'b1};
  localparam bit VP [NC]  = '{1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [15:0] ZC[NC] = '{16'h00E3, 16'h00E3, 16'h0ABC, 16'hF81F};

  logic clock = 1'b0;
  logic reset, ce;
  always #5 clock = ~clock;

  logic [15:0] col[NC];
  logic [10:0] rx[NC], ry[NC];
  logic        rv[NC], hs[NC], vs[NC], bn[NC], fs[NC], ls[NC];
  logic [7:0]  rd[NC], gr[NC], bl[NC];
  logic [15:0] fc[NC];

  for (genvar g = 0; g < NC; g++) begin : g_dut
    localparam int CW = RB[g] + GB[g] + BB[g];
    logic [CW-1:0] cin;
    assign cin = col[g][CW-1:0];
    vga_timing_gen #(
      .H_ACTIVE(HA[g]), .H_FP(HF[g]), .H_SYNC(HSW[g]), .H_BP(HB[g]),
      .V_ACTIVE(VA[g]), .V_FP(VF[g]), .V_SYNC(VSW[g]), .V_BP(VB[g]),
      .H_SYNC_POL(HP[g]), .V_SYNC_POL(VP[g]),
      .R_BITS(RB[g]), .G_BITS(GB[g]), .B_BITS(BB[g]),
      .PIPE_DELAY(PD[g]), .CNT_W(11), .FRAME_W(16)
    ) dut (
      .clock(clock), .reset(reset), .ce(ce), .color_in(cin),
      .req_x(rx[g]), .req_y(ry[g]), .req_valid(rv[g]),
      .hsync(hs[g]), .vsync(vs[g]),
      .red(rd[g]), .green(gr[g]), .blue(bl[g]),
      .blank_n(bn[g]), .frame_start(fs[g]), .line_start(ls[g]),
      .frame_count(fc[g])
    );
  end

  int errors = 0, checks = 0;
  int n = 0;          // ce edges since the last reset edge
  bit last_load = 0;  // previous edge was a ce load out of reset
  int t = 0;
  logic [15:0] lastc[NC];

  bit meas_en = 0;
  bit mprev[3];
  int mstart[3], mwid[3], mper[3];

  function automatic int ht(input int g); return HA[g] + HF[g] + HSW[g] + HB[g]; endfunction
  function automatic int vt(input int g); return VA[g] + VF[g] + VSW[g] + VB[g]; endfunction

  // Field replicated by concatenation, then the top 8 bits kept.
  function automatic logic [7:0] bexp(input logic [15:0] f, input int w);
    logic [31:0] acc;
    int reps;
    acc = 0;
    reps = (8 + w - 1) / w;
    for (int i = 0; i < reps; i++) acc = (acc << w) | (32'(f) & ((32'd1 << w) - 1));
    return 8'(acc >> (reps * w - 8));
  endfunction

  function automatic logic [15:0] pix(input int g, input int x, input int y);
    if (x == 0 && y == 0) return ZC[g];
    return 16'((x * 1103) ^ (y * 2917) ^ (g * 77));
  endfunction

  task automatic cmp(input int g, input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL cfg%0d %s at t=%0d: got %0h expected %0h", g, nm, t, a, e);
    end
  endtask

  task automatic check_inst(input int g);
    int k, x, y, xr, yr;
    bit act, hsa, vsa;
    logic [15:0] c;
    logic [7:0] er, eg, eb;
    xr = n % ht(g);
    yr = (n / ht(g)) % vt(g);
    cmp(g, "req_x", 32'(rx[g]), 32'(xr));
    cmp(g, "req_y", 32'(ry[g]), 32'(yr));
    cmp(g, "req_valid", 32'(rv[g]), 32'(xr < HA[g] && yr < VA[g]));
    k = n - 1 - PD[g];
    if (k < 0) begin
      cmp(g, "hsync", 32'(hs[g]), 32'(!HP[g]));
      cmp(g, "vsync", 32'(vs[g]), 32'(!VP[g]));
      cmp(g, "blank_n", 32'(bn[g]), 0);
      cmp(g, "rgb", {8'h0, rd[g], gr[g], bl[g]}, 0);
      cmp(g, "frame_start", 32'(fs[g]), 0);
      cmp(g, "line_start", 32'(ls[g]), 0);
      cmp(g, "frame_count", 32'(fc[g]), 0);
    end else begin
      x = k % ht(g);
      y = (k / ht(g)) % vt(g);
      act = x < HA[g] && y < VA[g];
      hsa = x >= HA[g] + HF[g] && x < HA[g] + HF[g] + HSW[g];
      vsa = y >= VA[g] + VF[g] && y < VA[g] + VF[g] + VSW[g];
      c  = lastc[g];
      er = act ? bexp(c >> (GB[g] + BB[g]), RB[g]) : 8'h0;
      eg = act ? bexp(c >> BB[g], GB[g]) : 8'h0;
      eb = act ? bexp(c, BB[g]) : 8'h0;
      cmp(g, "hsync", 32'(hs[g]), 32'(hsa ? HP[g] : !HP[g]));
      cmp(g, "vsync", 32'(vs[g]), 32'(vsa ? VP[g] : !VP[g]));
      cmp(g, "blank_n", 32'(bn[g]), 32'(act));
      cmp(g, "rgb", {8'h0, rd[g], gr[g], bl[g]}, {8'h0, er, eg, eb});
      cmp(g, "frame_start", 32'(fs[g]), 32'(last_load && x == 0 && y == 0));
      cmp(g, "line_start", 32'(ls[g]), 32'(last_load && x == 0 && y < VA[g]));
      cmp(g, "frame_count", 32'(fc[g]), 32'((k / (ht(g) * vt(g)) + 1) & 16'hFFFF));
    end
  endtask

  task automatic measure();
    bit s[3];
    s[0] = (hs[0] == 1'b0);
    s[1] = (vs[0] == 1'b0);
    s[2] = (hs[3] == 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (s[i] && !mprev[i]) begin
        if (mstart[i] >= 0) mper[i] = t - mstart[i];
        mstart[i] = t;
      end
      if (!s[i] && mprev[i] && mstart[i] >= 0) mwid[i] = t - mstart[i];
      mprev[i] = s[i];
    end
  endtask

  // Drive one clock of stimulus, advance the model, then check all instances.
  task automatic step(input bit r, input bit c);
    int k;
    reset = r;
    ce    = c;
    for (int g = 0; g < NC; g++) begin
      k = n - PD[g];
      if (c && !r && k >= 0) col[g] = pix(g, k % ht(g), (k / ht(g)) % vt(g));
      else                   col[g] = 16'($urandom);
      if (c && !r) lastc[g] = col[g];
    end
    @(negedge clock);
    t++;
    if (r)      begin n = 0; last_load = 0; end
    else if (c) begin n++;   last_load = 1; end
    else        last_load = 0;
    for (int g = 0; g < NC; g++) check_inst(g);
    if (meas_en) measure();
  endtask

  initial begin
    bit found;
    for (int g = 0; g < NC; g++) begin col[g] = '0; lastc[g] = '0; end
    for (int i = 0; i < 3; i++) begin mprev[i] = 0; mstart[i] = -1; mwid[i] = -1; mper[i] = -1; end
    reset = 1'b1;
    ce    = 1'b0;
    repeat (3) step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    // First pixel (0,0) reaches the pins PIPE_DELAY+1 clocks after release.
    meas_en = 1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    cmp(0, "lit_blank_before", 32'(bn[0]), 0);
    step(1'b0, 1'b1);
    cmp(0, "lit_blank_first", 32'(bn[0]), 1);
    cmp(0, "lit_red_E3", 32'(rd[0]), 32'h FF);
    cmp(0, "lit_green_E3", 32'(gr[0]), 32'h00);
    cmp(0, "lit_blue_E3", 32'(bl[0]), 32'hFF);
    cmp(0, "lit_frame_start", 32'(fs[0]), 1);
    cmp(0, "lit_frame_count", 32'(fc[0]), 1);
    step(1'b0, 1'b1);
    cmp(0, "lit_fs_one_clock", 32'(fs[0]), 0);
    cmp(3, "lit_red_F81F", 32'(rd[3]), 32'hFF);
    cmp(3, "lit_green_F81F", 32'(gr[3]), 32'h00);
    cmp(3, "lit_blue_F81F", 32'(bl[3]), 32'hFF);

    repeat (1000) step(1'b0, 1'b1);
    meas_en = 0;
    cmp(0, "lit_hsync_low_width", 32'(mwid[0]), 5);
    cmp(0, "lit_hsync_period", 32'(mper[0]), 32);
    cmp(0, "lit_vsync_low_width", 32'(mwid[1]), 64);
    cmp(0, "lit_vsync_period", 32'(mper[1]), 416);
    cmp(3, "lit_hsync_high_width", 32'(mwid[2]), 8);
    cmp(3, "lit_hsync_period", 32'(mper[2]), 40);

    // Half-rate enable.
    for (int i = 0; i < 1200; i++) step(1'b0, i[0] == 1'b0);

    // Reset with ce=0 while cfg0 is inside its hsync pulse.
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step(1'b0, 1'b1);
      if (hs[0] == 1'b0 && bn[0] == 1'b0) found = 1;
    end
    cmp(0, "hsync_wait", 32'(found), 1);
    step(1'b1, 1'b0);
    cmp(0, "lit_hsync_reset", 32'(hs[0]), 1);
    cmp(0, "lit_fc_reset", 32'(fc[0]), 0);
    cmp(0, "lit_req_reset", {10'h0, rx[0], ry[0]}, 0);

    // Random enable with occasional resets.
    for (int i = 0; i < 2500; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
